// File: rtl/instr_pack.sv
// Shared definitions for the 9-bit CPU: sequencer state encoding and the
// subroutine entry table used by jtsr. Imported by instruction-memory
// programs, the decoder and the PC sequencer.
package instr_pack;

    localparam int unsigned SUB_ENTRIES = 16;
    localparam int unsigned SUB_ADDR_W  = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pcseq_state_t;

    // Subroutine entry addresses, indexed by the jtsr call index.
    localparam logic [SUB_ADDR_W-1:0] SUB_TABLE [SUB_ENTRIES] = '{
        10'd200, 10'd60,  10'd300, 10'd400,
        10'd500, 10'd600, 10'd700, 10'd800,
        10'd900, 10'd1000, 10'd110, 10'd120,
        10'd130, 10'd140, 10'd150, 10'd170
    };

endpackage

// File: rtl/ret_stack.sv
// Bounded LIFO of return addresses.
// Ports: clk, rst_n (sync, active-low), clr (empty the stack), push/push_data,
// pop, top (combinational top-of-stack, 0 when empty), full, empty.
// A push at full overwrites the top entry; a pop at empty leaves sp at 0.
module ret_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);

    localparam int unsigned SP_W = $clog2(DEPTH + 1);
    localparam int unsigned AW   = $clog2(DEPTH);

    logic [W-1:0]    mem [DEPTH];
    logic [SP_W-1:0] sp;
    logic [AW-1:0]   top_idx;
    logic [AW-1:0]   wr_idx;

    assign full    = (sp == SP_W'(DEPTH));
    assign empty   = (sp == '0);
    assign top_idx = AW'(sp - SP_W'(1));
    // At full the write lands on the current top entry instead of growing.
    assign wr_idx  = full ? AW'(DEPTH - 1) : AW'(sp);
    assign top     = empty ? '0 : mem[top_idx];

    // Stack pointer
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + SP_W'(1);
        end else if (pop && !empty) begin
            sp <= sp - SP_W'(1);
        end
    end

    // Entry storage, intentionally not reset
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/HALT control and next-PC selection
// (sequential, branch, skip, call via SUB_TABLE, return) with a return stack.
// Ports: clk, rst_n (sync, active-low), start/start_addr, stall, br_take/
// br_target, skip_take/skip_off, call/call_idx, ret, halt; outputs pc,
// running, done and, with PCSEQ_STACK_CHK_EN defined, sticky stack_err.
// RUN priority: stall > halt > ret > call > br_take > skip_take > pc+1.
module pc_sequencer
    import instr_pack::*;
#(
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned PC_W        = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [PC_W-1:0] start_addr,
    input  logic            stall,
    input  logic            br_take,
    input  logic [PC_W-1:0] br_target,
    input  logic            skip_take,
    input  logic [2:0]      skip_off,
    input  logic            call,
    input  logic [3:0]      call_idx,
    input  logic            ret,
    input  logic            halt,
    output logic [PC_W-1:0] pc,
    output logic            running,
    output logic            done
`ifdef PCSEQ_STACK_CHK_EN
    ,
    output logic            stack_err
`endif
);

    pcseq_state_t    state, state_d;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] pc_inc;
    logic            running_d;
    logic            done_d;
    logic            push;
    logic            pop;
    logic            clr;
    logic [PC_W-1:0] stk_top;
    logic            stk_full;
    logic            stk_empty;

    assign pc_inc = pc + PC_W'(1);

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (PC_W)
    ) u_ret_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc      <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_d;
            pc      <= pc_d;
            running <= running_d;
            done    <= done_d;
        end
    end

    // Next state, next PC and stack strobes
    always_comb begin
        state_d   = state;
        pc_d      = pc;
        running_d = running;
        done_d    = done;
        push      = 1'b0;
        pop       = 1'b0;
        clr       = 1'b0;
        case (state)
            IDLE, HALT: begin
                if (start) begin
                    state_d   = RUN;
                    pc_d      = start_addr;
                    running_d = 1'b1;
                    done_d    = 1'b0;
                    clr       = 1'b1;
                end
            end
            RUN: begin
                if (stall) begin
                    pc_d = pc;
                end else if (halt) begin
                    state_d   = HALT;
                    running_d = 1'b0;
                    done_d    = 1'b1;
                end else if (ret) begin
                    pop  = 1'b1;
                    pc_d = stk_top;
                end else if (call) begin
                    push = 1'b1;
                    pc_d = PC_W'(SUB_TABLE[call_idx]);
                end else if (br_take) begin
                    pc_d = br_target;
                end else if (skip_take) begin
                    pc_d = pc_inc + PC_W'(skip_off);
                end else begin
                    pc_d = pc_inc;
                end
            end
            default: begin
                state_d   = IDLE;
                running_d = 1'b0;
                done_d    = 1'b0;
            end
        endcase
    end

`ifdef PCSEQ_STACK_CHK_EN
    // Sticky overflow/underflow flag, cleared on relaunch
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            stack_err <= 1'b0;
        end else if ((push && stk_full) || (pop && stk_empty)) begin
            stack_err <= 1'b1;
        end
    end
`else
    logic unused_stk;
    assign unused_stk = stk_full ^ stk_empty;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by
// randomized strobes, compared each cycle against a queue-based model.
module tb_pc_sequencer;
    import instr_pack::*;

    localparam int DEPTH = 4;
    localparam int MASK  = 1023;

    logic       clk = 1'b0;
    logic       rst_n, start, stall, br_take, skip_take, call, ret, halt;
    logic [9:0] start_addr, br_target, pc;
    logic [2:0] skip_off;
    logic [3:0] call_idx;
    logic       running, done;
`ifdef PCSEQ_STACK_CHK_EN
    logic       stack_err;
`endif

    always #5 clk = ~clk;

    pc_sequencer #(.STACK_DEPTH(DEPTH), .PC_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .stall(stall), .br_take(br_take), .br_target(br_target),
        .skip_take(skip_take), .skip_off(skip_off), .call(call),
        .call_idx(call_idx), .ret(ret), .halt(halt), .pc(pc),
        .running(running), .done(done)
`ifdef PCSEQ_STACK_CHK_EN
        , .stack_err(stack_err)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Reference model: 0 = idle, 1 = run, 2 = halted
    int m_st  = 0;
    int m_pc  = 0;
    int m_stk[$];
    int m_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_strobes();
        start = 0; stall = 0; br_take = 0; skip_take = 0;
        call = 0; ret = 0; halt = 0;
    endtask

    task automatic model_step();
        if (!rst_n) begin
            m_st = 0; m_pc = 0; m_err = 0; m_stk.delete();
        end else if (m_st != 1) begin
            if (start) begin
                m_st = 1; m_pc = int'(start_addr); m_err = 0; m_stk.delete();
            end
        end else if (stall) begin
            // hold
        end else if (halt) begin
            m_st = 2;
        end else if (ret) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin m_pc = 0; m_err = 1; end
        end else if (call) begin
            if (m_stk.size() == DEPTH) begin
                m_stk[DEPTH-1] = (m_pc + 1) & MASK;
                m_err = 1;
            end else m_stk.push_back((m_pc + 1) & MASK);
            m_pc = int'(SUB_TABLE[call_idx]);
        end else if (br_take) begin
            m_pc = int'(br_target);
        end else if (skip_take) begin
            m_pc = (m_pc + 1 + int'(skip_off)) & MASK;
        end else begin
            m_pc = (m_pc + 1) & MASK;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("pc", 32'(pc), 32'(m_pc));
        chk("running", 32'(running), 32'(m_st == 1));
        chk("done", 32'(done), 32'(m_st == 2));
`ifdef PCSEQ_STACK_CHK_EN
        chk("stack_err", 32'(stack_err), 32'(m_err));
`endif
    endtask

    // Halt if running, then start at addr
    task automatic launch(input int addr);
        clear_strobes();
        if (m_st == 1) begin halt = 1; tick(); halt = 0; end
        start = 1; start_addr = 10'(addr); tick(); start = 0;
    endtask

    task automatic run_to(input int target);
        int budget = 1100;
        clear_strobes();
        while (m_pc != target && budget > 0) begin tick(); budget--; end
        chk("run_to_budget", 32'(budget > 0), 32'd1);
    endtask

    task automatic do_call(input int idx);
        call = 1; call_idx = 4'(idx); tick(); call = 0;
    endtask

    task automatic do_ret();
        ret = 1; tick(); ret = 0;
    endtask

    initial begin
        clear_strobes();
        start_addr = 0; br_target = 0; skip_off = 0; call_idx = 0;
        rst_n = 0;
        tick(); tick();
        chk("rst_pc", 32'(pc), 0);
        chk("rst_running", 32'(running), 0);
        chk("rst_done", 32'(done), 0);
        rst_n = 1;
        tick();
        chk("idle_pc", 32'(pc), 0);

        // Sequential run from 0
        launch(0);
        chk("seq0", 32'(pc), 0);
        chk("seq_running", 32'(running), 1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("seq", 32'(pc), 32'(k));
        end

        // Register branch
        launch(30);
        br_take = 1; br_target = 15; tick(); br_take = 0;
        chk("branch", 32'(pc), 15);

        // Skips, including wrap
        launch(40);
        skip_take = 1; skip_off = 2; tick(); skip_take = 0;
        chk("skip", 32'(pc), 43);
        launch(1020);
        skip_take = 1; skip_off = 7; tick(); skip_take = 0;
        chk("skip_wrap", 32'(pc), 4);

        // Call / return
        launch(19);
        do_call(1);
        chk("call", 32'(pc), 60);
        run_to(69);
        do_ret();
        chk("ret", 32'(pc), 20);

        // Four nested calls unwind in reverse
        launch(5);
        do_call(2); chk("nest_c1", 32'(pc), 300);
        do_call(3); chk("nest_c2", 32'(pc), 400);
        do_call(4); chk("nest_c3", 32'(pc), 500);
        do_call(5); chk("nest_c4", 32'(pc), 600);
        do_ret(); chk("nest_r1", 32'(pc), 501);
        do_ret(); chk("nest_r2", 32'(pc), 401);
        do_ret(); chk("nest_r3", 32'(pc), 301);
        do_ret(); chk("nest_r4", 32'(pc), 6);

        // Overflow and underflow
        launch(100);
        do_call(6); do_call(7); do_call(8); do_call(9);
`ifdef PCSEQ_STACK_CHK_EN
        chk("err_before", 32'(stack_err), 0);
`endif
        do_call(10);
        chk("ovf_call", 32'(pc), 110);
`ifdef PCSEQ_STACK_CHK_EN
        chk("err_after", 32'(stack_err), 1);
`endif
        do_ret(); chk("ovf_r1", 32'(pc), 1001);
        do_ret(); chk("ovf_r2", 32'(pc), 801);
        do_ret(); chk("ovf_r3", 32'(pc), 701);
        do_ret(); chk("ovf_r4", 32'(pc), 101);
        do_ret(); chk("ovf_r5", 32'(pc), 0);

        // Stall then halt
        launch(10);
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall", 32'(pc), 10);
        end
        stall = 0;
        run_to(52);
        halt = 1; tick(); halt = 0;
        chk("halt_done", 32'(done), 1);
        chk("halt_pc", 32'(pc), 52);
        chk("halt_running", 32'(running), 0);
        br_take = 1; br_target = 3; tick(); br_take = 0;
        chk("halt_hold", 32'(pc), 52);
        chk("halt_done2", 32'(done), 1);
        start = 1; start_addr = 7; tick(); start = 0;
        chk("relaunch_pc", 32'(pc), 7);
        chk("relaunch_done", 32'(done), 0);

        // Reset mid-run masks strobes
        br_take = 1; br_target = 99; rst_n = 0; tick();
        chk("midrst_pc", 32'(pc), 0);
        chk("midrst_running", 32'(running), 0);
        rst_n = 1; clear_strobes();

        // Randomized strobes, occasionally several at once
        for (int n = 0; n < 4000; n++) begin
            int r;
            clear_strobes();
            r = int'($urandom_range(0, 99));
            br_target  = 10'($urandom);
            start_addr = 10'($urandom);
            skip_off   = 3'($urandom);
            call_idx   = 4'($urandom);
            if (r < 8) stall = 1;
            else if (r < 11) halt = 1;
            else if (r < 26) ret = 1;
            else if (r < 43) call = 1;
            else if (r < 53) br_take = 1;
            else if (r < 63) skip_take = 1;
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 5))
                    0: stall = 1;
                    1: halt = 1;
                    2: ret = 1;
                    3: call = 1;
                    4: br_take = 1;
                    default: skip_take = 1;
                endcase
            end
            if ($urandom_range(0, 9) == 0) start = 1;
            rst_n = ($urandom_range(0, 299) != 0);
            tick();
        end
        rst_n = 1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the 9-bit CPU. It drives `pc` into the combinational instruction memory and selects the next PC from the decoder's control strobes: sequential, register-target branch, short forward skip, subroutine call by table index, or return. It owns the start/done handshake with the testbench or top level, and a bounded hardware return stack.

## Interface
- `STACK_DEPTH`, 4: return-stack entries (power of two, 2..16).
- `PC_W`, 10: PC width, which matches the instruction-memory address.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  a one-cycle pulse in IDLE begins execution at `start_addr`.
- `start_addr`  in  PC_W  first instruction address.
- `stall`  in  1  holds the PC and stack for this cycle.
- `br_take`  in  1  taken branch (bnzr); the target is `br_target`.
- `br_target`  in  PC_W  absolute branch target, taken from a register.
- `skip_take`  in  1  taken jizr; next PC = pc + 1 + `skip_off`.
- `skip_off`  in  3  skip distance, unsigned.
- `call`  in  1  jtsr; the target comes from the subroutine table.
- `call_idx`  in  4  subroutine table index.
- `ret`  in  1  rfsr; pop the return address.
- `halt`  in  1  func done.
- `pc`  out  PC_W  current fetch address.
- `running`  out  1  high in RUN.
- `done`  out  1  high in HALT; it stays high until `start` or reset.
- `stack_err`  out  1  sticky error flag; present only with `PCSEQ_STACK_CHK_EN`.

## Operation
- The FSM has three states: IDLE, RUN and HALT.
  - IDLE goes to RUN on `start`, loading `pc` ← `start_addr`.
  - RUN goes to HALT on `halt` when not stalled; `pc` freezes at the address of the done instruction.
  - HALT goes to RUN on `start`. This reloads the PC, clears the stack pointer and drops `done`.
- `start` is ignored in RUN. All strobes are ignored in IDLE and HALT.
- The next PC in RUN is chosen by fixed priority: `stall` > `halt` > `ret` > `call` > `br_take` > `skip_take` > pc+1.
  - The decoder asserts at most one strobe per cycle. The priority defines the result only if it asserts more than one.
- `call`:
  - Push pc+1.
  - Set `pc` ← `SUB_TABLE[call_idx]`.
- `ret`: pop the top of stack into `pc`.
- Arithmetic is modulo 2^PC_W. pc+1 and pc+1+`skip_off` wrap from 1023 to 0 without any flag.
- Stack pointer `sp` ranges 0..STACK_DEPTH.
  - A push at full overwrites the top entry; `sp` holds.
  - A pop at empty returns 0; `sp` holds.
- Reset values:
  - state = IDLE, `pc` = 0, `sp` = 0
  - `running` = 0, `done` = 0, `stack_err` = 0
  - The stack contents are not reset.

## Timing
- `pc`, `running`, `done` and `stack_err` are registered outputs.
- The instruction at `pc` is valid combinationally in the same cycle. Strobes decoded from it are sampled at the next edge, so every control transfer takes effect one cycle after its instruction. There are no delay slots.
- `start` in cycle N gives `pc` = `start_addr` and `running` = 1 in cycle N+1.
- `halt` in cycle N gives `done` = 1 and `running` = 0 in cycle N+1.
- Reset asserted mid-RUN takes effect at the next edge; no strobe issued in that cycle has any effect.
- A simultaneous push and pop cannot occur, because `ret` outranks `call`.

## Configuration
- `PCSEQ_STACK_CHK_EN` defined:
  - `stack_err` is set by a push at full or a pop at empty.
  - It stays set until reset or `start`.
  - The overwrite/return-0 behaviour above is unchanged.
- `PCSEQ_STACK_CHK_EN` undefined: the `stack_err` port and its logic are absent.

## Structure
- `instr_pack` gets the following, shared with the instruction-memory programs and the decoder:
  - `pcseq_state_t` (enum IDLE/RUN/HALT).
  - `SUB_TABLE`, a localparam array of 16 × 10-bit subroutine entry addresses.
- Sub-module `ret_stack`: a parameterized LIFO with push, pop, full and empty, plus a combinational top-of-stack read.

## Test plan
- Reset, then `start` with `start_addr` = 0 and no strobes:
  - `pc` steps 0, 1, 2, 3.
  - `running` = 1 from the cycle after `start`.
- `br_take` with `br_target` = 15 at pc = 30 → next `pc` = 15.
- `skip_take` with `skip_off` = 2 at pc = 40 → `pc` = 43. `skip_off` = 7 at pc = 1020 → `pc` = 4 (wrap).
- Call/return with `SUB_TABLE[1]` = 60:
  - `call` `call_idx` = 1 at pc = 19 → `pc` = 60.
  - Then `ret` at pc = 69 → `pc` = 20.
  - Four nested calls, then four returns, unwind in the correct order.
- Five calls with depth 4, then five returns:
  - The fifth push overwrites the top entry; the fifth pop gives `pc` = 0.
  - With `PCSEQ_STACK_CHK_EN`, `stack_err` = 1 after the fifth call.
- `stall` held for 3 cycles at pc = 10 → `pc` stays 10. `halt` at pc = 52 → `done` = 1 and `pc` = 52 until `start` relaunches the program.
